// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM strobe responder.
package sram_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_VALID,
    WR_WAIT,
    WR_HOLD
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR
  } access_e;

  // Expands the active-low byte-lane strobes into a 16-bit data mask.
  function automatic logic [15:0] lane_mask(input logic ub_n, input logic lb_n);
    return {{8{~ub_n}}, {8{~lb_n}}};
  endfunction

endpackage

// File: rtl/sram_array.sv
// Word array with per-byte write enables and a registered read port.
// Deliberately has no reset so contents survive a controller reset.
module sram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [1:0]            we,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [2**DEPTH_LOG2];
  logic [15:0] rdata_q;

  // Byte-lane writes and read-before-write registered read of the same address.
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Responder for the LC-3 active-low SRAM strobes with enforced access latency.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access in progress; a new read or write may start here
// RD_WAIT  | OE held low, counting toward READ_LAT
// RD_VALID | read data registered; Data_out refreshed while read is held
// WR_WAIT  | WE held low, counting toward WRITE_LAT commit
// WR_HOLD  | write committed; waiting for WE/CE release
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_in,
  output logic [15:0]       Data_out,
  output logic              Data_valid,
  output logic              Wr_ack,
  output logic              Err
);

  // Counter values at which the read is registered and the write commits.
  localparam logic [CNT_W-1:0] RD_TC = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_TC = CNT_W'(WRITE_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [15:0]        mask_q, mask_d;
  logic               wr_ack_q, wr_ack_d;
  logic               err_q, err_d;
  logic [1:0]         wr_be;
  logic [1:0]         arr_we;
  logic [15:0]        lane;
  logic [15:0]        rd_data;
  access_e            acc;
  logic               start;

  // Decode the strobes into an access type; WE wins over OE.
  always_comb begin
    acc = NONE;
    if (!Mem_CE) begin
      if (!Mem_WE)      acc = WR;
      else if (!Mem_OE) acc = RD;
    end
  end

  assign lane    = lane_mask(Mem_UB, Mem_LB);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    valid_d  = 1'b0;
    mask_d   = mask_q;
    wr_ack_d = 1'b0;
    err_d    = 1'b0;
    wr_be    = 2'b00;
    start    = 1'b0;

    case (state_q)
      IDLE: start = 1'b1;

      RD_WAIT: begin
        case (acc)
          RD: begin
            if (ADDR != addr_q) begin
              start = 1'b1;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == RD_TC) begin
                state_d = RD_VALID;
                valid_d = 1'b1;
                mask_d  = lane;
              end
            end
          end
          WR: start = 1'b1;
          default: begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        endcase
      end

      RD_VALID: begin
        if (acc == RD && ADDR == addr_q) begin
          valid_d = 1'b1;
          mask_d  = lane;
        end else begin
          start = 1'b1;
        end
      end

      WR_WAIT: begin
        if (acc == WR) begin
          if (ADDR != addr_q) begin
            start = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == WR_TC) begin
              wr_be    = ~{Mem_UB, Mem_LB};
              wr_ack_d = 1'b1;
              state_d  = WR_HOLD;
            end
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      WR_HOLD: begin
        if (acc != WR) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Begin (or restart) an access from counter=1 at the current address.
    if (start) begin
      case (acc)
        RD: begin
          addr_d = ADDR;
          cnt_d  = CNT_ONE;
          if (RD_TC == CNT_ONE) begin
            state_d = RD_VALID;
            valid_d = 1'b1;
            mask_d  = lane;
          end else begin
            state_d = RD_WAIT;
          end
        end
        WR: begin
          addr_d = ADDR;
          cnt_d  = CNT_ONE;
          if (WR_TC == CNT_ONE) begin
            wr_be    = ~{Mem_UB, Mem_LB};
            wr_ack_d = 1'b1;
            state_d  = WR_HOLD;
          end else begin
            state_d = WR_WAIT;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      mask_q   <= '0;
      wr_ack_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      wr_ack_q <= wr_ack_d;
      err_q    <= err_d;
    end
  end

  // A commit only happens while ADDR matches the latched address, so the
  // live ADDR is the correct write index. Reset drops any in-flight commit.
  assign arr_we = Reset ? 2'b00 : wr_be;

  sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (Clk),
    .addr  (ADDR[DEPTH_LOG2-1:0]),
    .we    (arr_we),
    .wdata (Data_in),
    .rdata (rd_data)
  );

  assign Data_out   = valid_q ? (rd_data & mask_q) : 16'h0000;
  assign Data_valid = valid_q;
  assign Wr_ack     = wr_ack_q;
  assign Err        = err_q;

endmodule
